// File: rtl/handshake_const_arbiter_pkg.sv
// Shared helpers for the constant-channel arbiter: index width derivation
// and the packing convention of the per-requester constant table.
package handshake_const_arbiter_pkg;

   // Ceiling log2, never below 1 so a single requester still gets a 1-bit index.
   function automatic int idx_width(input int n);
      int w;
      w = 0;
      for (int k = 0; k < 32; k++) begin
         if ((1 << w) < n) w++;
      end
      return (w < 1) ? 1 : w;
   endfunction

   // Requester i's constant lives at bit offset i*width of the packed table.
   function automatic int const_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/handshake_const_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_priority_picker
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any
);

   // Scan requesters starting at the pointer; the first hit wins.
   always_comb begin
      int idx;
      grant_oh  = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any && req[idx]) begin
            any           = 1'b1;
            grant_oh[idx] = 1'b1;
            grant_idx     = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/handshake_const_arbiter.sv
// Round-robin arbiter exchanging requester control tokens for per-requester
// constants on one registered output channel (1-cycle latency, full rate).
module handshake_const_arbiter
   import handshake_const_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 18,
   parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONSTS =
      {18'h12345, 18'h3FFFF, 18'h00001, 18'h1AD57},
   localparam int IDX_W = idx_width(NUM_REQ)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    ins_valid,
   output logic [NUM_REQ-1:0]    ins_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic [IDX_W-1:0]      outs_index,
   output logic                  outs_valid,
   input  logic                  outs_ready
);

   logic [DATA_WIDTH-1:0] outs_q, outs_d;
   logic [IDX_W-1:0]      outs_index_q, outs_index_d;
   logic                  outs_valid_q, outs_valid_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

   logic [NUM_REQ-1:0]    grant_oh;
   logic [IDX_W-1:0]      grant_idx;
   logic                  any;
   logic                  load;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req       (ins_valid),
      .ptr       (rr_ptr_q),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .any       (any)
   );

   // The slot can accept a new token when empty or draining this cycle.
   assign load      = !outs_valid_q || outs_ready;
   assign ins_ready = (load && any && !rst) ? grant_oh : '0;

   // Next-state: capture the granted constant and advance the pointer past it.
   always_comb begin
      outs_d       = outs_q;
      outs_index_d = outs_index_q;
      outs_valid_d = outs_valid_q;
      rr_ptr_d     = rr_ptr_q;
      if (load) begin
         if (any) begin
            outs_d       = CONSTS[const_lsb(int'(grant_idx), DATA_WIDTH) +: DATA_WIDTH];
            outs_index_d = grant_idx;
            outs_valid_d = 1'b1;
            if (int'(grant_idx) == NUM_REQ - 1) rr_ptr_d = '0;
            else                                rr_ptr_d = IDX_W'(int'(grant_idx) + 1);
         end else begin
            outs_valid_d = 1'b0;
         end
      end
   end

   // Output register and pointer; reset discards any held token.
   always_ff @(posedge clk) begin
      if (rst) begin
         outs_q       <= '0;
         outs_index_q <= '0;
         outs_valid_q <= 1'b0;
         rr_ptr_q     <= '0;
      end else begin
         outs_q       <= outs_d;
         outs_index_q <= outs_index_d;
         outs_valid_q <= outs_valid_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign outs       = outs_q;
   assign outs_index = outs_index_q;
   assign outs_valid = outs_valid_q;

endmodule

// File: tb/tb_handshake_const_arbiter.sv
// Scoreboard bench: the driver predicts grants from a round-robin reference
// and queues expected tokens; a monitor checks every presented output.
module tb_handshake_const_arbiter;

   localparam int N  = 4;
   localparam int DW = 18;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  ins_valid;
   logic [N-1:0]  ins_ready;
   logic [DW-1:0] outs;
   logic [IW-1:0] outs_index;
   logic          outs_valid;
   logic          outs_ready;

   always #5 clk = ~clk;

   handshake_const_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs       (outs),
      .outs_index (outs_index),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] idx;
   } tok_t;

   tok_t          sb[$];
   logic [DW-1:0] exp_const [N] = '{18'h1AD57, 18'h00001, 18'h3FFFF, 18'h12345};
   int            model_ptr;
   int            last_grant;
   int            waits [N];
   int            errors = 0;
   int            checks = 0;
   bit            mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs, predict the grant, check ready, queue the token.
   task automatic step(input logic [N-1:0] v, input logic r, input logic rs);
      logic [N-1:0] exp_rdy;
      int  g;
      bit  load;
      tok_t t;
      @(negedge clk);
      ins_valid  = v;
      outs_ready = r;
      rst        = rs;
      #2;
      exp_rdy    = '0;
      g          = -1;
      last_grant = -1;
      load       = (sb.size() == 0) || r;
      if (!rs) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (model_ptr + k) % N;
            if (g < 0 && v[i]) g = i;
         end
      end
      if (g >= 0 && load) exp_rdy[g] = 1'b1;
      chk("ins_ready", 32'(ins_ready), 32'(exp_rdy));
      // Fairness on what the DUT actually granted.
      if (!rs && ins_ready != '0) begin
         for (int i = 0; i < N; i++) begin
            if (ins_ready[i]) waits[i] = 0;
            else if (v[i]) begin
               waits[i]++;
               chk("fair_wait_le_3", 32'(waits[i] <= N - 1), 32'd1);
            end else waits[i] = 0;
         end
      end
      if (rs) begin
         sb.delete();
         model_ptr = 0;
         for (int i = 0; i < N; i++) waits[i] = 0;
      end else if (g >= 0 && load) begin
         t.data = exp_const[g];
         t.idx  = IW'(g);
         sb.push_back(t);
         model_ptr  = (g + 1) % N;
         last_grant = g;
      end
   endtask

   // Monitor: check presented output against the queue head, pop on handshake.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (mon_en) begin
            chk("outs_valid", 32'(outs_valid), 32'(sb.size() > 0));
            if (outs_valid && sb.size() > 0) begin
               chk("outs", 32'(outs), 32'(sb[0].data));
               chk("outs_index", 32'(outs_index), 32'(sb[0].idx));
            end
         end
         #2;
         if (mon_en && !rst && outs_valid && outs_ready && sb.size() > 0)
            void'(sb.pop_front());
      end
   end

   initial begin
      logic [N-1:0] hv;
      rst        = 1'b1;
      ins_valid  = '1;
      outs_ready = 1'b1;
      model_ptr  = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;

      // Reset with every requester valid.
      step(4'hF, 1'b1, 1'b1);
      step(4'hF, 1'b1, 1'b1);
      chk("rst_outs_valid", 32'(outs_valid), 32'd0);
      chk("rst_outs", 32'(outs), 32'd0);
      chk("rst_outs_index", 32'(outs_index), 32'd0);
      mon_en = 1'b1;

      // First grant after release goes to requester 0.
      step(4'hF, 1'b1, 1'b0);
      chk("first_grant", 32'(ins_ready), 32'h1);
      // Single requester 2.
      step(4'b0100, 1'b1, 1'b0);
      chk("single_ready", 32'(ins_ready), 32'h4);
      step(4'b0000, 1'b1, 1'b0);
      chk("single_outs", 32'(outs), 32'h3FFFF);
      // All valid, full throughput for 8 cycles.
      for (int c = 0; c < 8; c++) step(4'hF, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);

      // Backpressure while index 1 is held.
      step(4'b0010, 1'b1, 1'b0);
      for (int c = 0; c < 5; c++) step(4'hF, 1'b0, 1'b0);
      chk("bp_index_held", 32'(outs_index), 32'd1);
      step(4'hF, 1'b1, 1'b0);
      chk("bp_release_grant", 32'(ins_ready), 32'h4);
      step(4'b0000, 1'b1, 1'b0);

      // Wrap: pointer now 3, requesters 3 and 0.
      step(4'b1001, 1'b1, 1'b0);
      chk("wrap_g3", 32'(ins_ready), 32'h8);
      step(4'b0001, 1'b1, 1'b0);
      chk("wrap_g0", 32'(ins_ready), 32'h1);
      chk("wrap_outs", 32'(outs), 32'h12345);
      step(4'b1010, 1'b1, 1'b0);
      chk("wrap_ptr1", 32'(ins_ready), 32'h2);
      step(4'b0000, 1'b1, 1'b0);

      // Reset while a token is held under backpressure.
      step(4'b0001, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b1, 1'b0);
      chk("midrst_valid", 32'(outs_valid), 32'd0);
      step(4'b1001, 1'b1, 1'b0);
      chk("midrst_ptr0", 32'(ins_ready), 32'h1);
      step(4'b0000, 1'b1, 1'b0);

      // Randomized traffic; requesters hold valid until their handshake.
      hv = '0;
      for (int c = 0; c < 3000; c++) begin
         logic r;
         logic rs;
         hv = hv | N'($urandom_range(0, 15) & $urandom_range(0, 15));
         r  = ($urandom_range(0, 3) != 0);
         rs = ($urandom_range(0, 299) == 0);
         step(hv, r, rs);
         if (last_grant >= 0) hv[last_grant] = 1'b0;
      end
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/handshake_const_arbiter.md
# handshake_const_arbiter

Round-robin arbiter sharing a single registered constant-output channel among NUM_REQ control-token requesters in the elastic dataflow fabric. Each requester's control token is exchanged for that requester's compile-time constant, tagged with the requester index. The block replaces NUM_REQ parallel constant units feeding a shared consumer. It provides one-cycle latency and full throughput, with fair, starvation-free arbitration under backpressure.

## Interface
- NUM_REQ, 4, number of requesting control channels (≥1)
- DATA_WIDTH, 18, constant width
- CONSTS, {18'h12345, 18'h3FFFF, 18'h00001, 18'h1AD57}, packed table; requester i's constant is CONSTS[i*DATA_WIDTH +: DATA_WIDTH]
- IDX_W, clog2(NUM_REQ) (minimum 1), derived; not overridden
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ins_valid  in  NUM_REQ  per-requester control token valid
- ins_ready  out  NUM_REQ  per-requester ready; one-hot or zero
- outs  out  DATA_WIDTH  registered constant of the granted requester
- outs_index  out  IDX_W  registered index of the granted requester
- outs_valid  out  1  output token valid
- outs_ready  in  1  consumer ready

## Operation
- State:
  - output register: outs, outs_index, outs_valid
  - round-robin pointer rr_ptr (IDX_W bits), the highest-priority requester.
- load = !outs_valid || outs_ready (output slot free or draining this cycle).
- Grant g: the first i with ins_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- ins_ready[g] = load && any(ins_valid); all other ins_ready bits are 0. ins_ready is combinational from ins_valid, outs_ready and registered state.
- On load with a grant:
  - outs ← CONSTS[g], outs_index ← g, outs_valid ← 1
  - rr_ptr ← (g == NUM_REQ-1) ? 0 : g+1.
- On load with no valid input: outs_valid ← 0; outs, outs_index and rr_ptr hold.
- No load (outs_valid && !outs_ready): every register holds and all ins_ready are 0.
- NUM_REQ=1: the pointer stays 0 and the block degenerates to a one-deep registered constant.
- Dropping ins_valid before a handshake is a protocol violation. It is not checked.

## Timing
- Reset values:
  - outs = 0, outs_index = 0, outs_valid = 0, rr_ptr = 0
  - ins_ready = 0 throughout any cycle with rst=1.
- Latency: input handshake in cycle t gives outs_valid=1 with the data in cycle t+1.
- Throughput: one token per cycle while outs_ready=1.
- Simultaneous drain and load in the same cycle is supported.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
- Reset mid-operation: a held output token is discarded without handshake. Cycle after rst: outs_valid=0, rr_ptr=0.
- Output data is stable while outs_valid && !outs_ready.

## Structure
- Shared package/header holds:
  - the clog2 helper and IDX_W derivation
  - the CONSTS packing convention (index i at bit offset i*DATA_WIDTH).
- Single natural sub-module: rr_priority_picker. It is combinational: inputs req[NUM_REQ] and ptr; outputs grant one-hot, grant index and any.
- The top level holds the output register, rr_ptr update and ready gating.

## Test plan
All cases use the default parameters.
- Reset: rst=1 for 2 cycles with all ins_valid=1 -> ins_ready=0000, outs_valid=0, outs=0, outs_index=0. After release, first grant is 0.
- Single requester: ins_valid=0100, outs_ready=1 at t -> ins_ready=0100 at t. At t+1: outs=0x3FFFF, outs_index=2, outs_valid=1. Next grant pointer is 3.
- All requesters valid, outs_ready=1 for 8 cycles -> outs_index sequence 0,1,2,3,0,1,2,3; outs sequence 0x1AD57,0x00001,0x3FFFF,0x12345 repeating.
- Backpressure: outs_valid=1 (index 1), outs_ready=0 for 5 cycles with all inputs valid -> outs stable, ins_ready=0000. When outs_ready=1, grant is 2 in the same cycle, visible on outs the next cycle.
- Wrap: rr_ptr=3, ins_valid=1001 -> grants 3 then 0 on consecutive cycles. outs 0x12345 then 0x1AD57; rr_ptr ends at 1.
- Reset mid-stream: rst=1 while outs_valid=1, outs_ready=0 -> next cycle outs_valid=0 and rr_ptr=0. The dropped token never handshakes.
